// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus source indices and arbitration mode constants
package bus_pkg;

    localparam int SRC_R0     = 0;
    localparam int SRC_R1     = 1;
    localparam int SRC_R2     = 2;
    localparam int SRC_R3     = 3;
    localparam int SRC_R4     = 4;
    localparam int SRC_R5     = 5;
    localparam int SRC_R6     = 6;
    localparam int SRC_R7     = 7;
    localparam int SRC_R8     = 8;
    localparam int SRC_R9     = 9;
    localparam int SRC_R10    = 10;
    localparam int SRC_R11    = 11;
    localparam int SRC_R12    = 12;
    localparam int SRC_R13    = 13;
    localparam int SRC_R14    = 14;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_C      = 23;

    localparam int BUS_N_SRC  = 24;

    localparam int ARB_FIXED  = 0;
    localparam int ARB_RR     = 1;

    typedef logic [$clog2(BUS_N_SRC)-1:0] bus_src_t;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational first-set search starting at a pointer, wrapping
module rr_priority_pick #(
    parameter int N_SRC = 24,
    parameter int SEL_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] winner,
    output logic             found
);

    logic [N_SRC-1:0]   hi_mask;
    logic [2*N_SRC-1:0] dbl;
    logic [SEL_W:0]     idx;

    // Low half holds requests at/above start, high half the full vector, so the
    // lowest set bit of the concatenation is the wrapped winner.
    always_comb begin
        hi_mask = '0;
        for (int j = 0; j < N_SRC; j++) begin
            hi_mask[j] = (j >= int'(start));
        end
        dbl = {req, req & hi_mask};
        idx = '0;
        for (int i = 2*N_SRC-1; i >= 0; i--) begin
            if (dbl[i]) begin
                idx = (SEL_W+1)'(i);
            end
        end
        found = |req;
        if (idx >= (SEL_W+1)'(N_SRC)) begin
            winner = SEL_W'(idx - (SEL_W+1)'(N_SRC));
        end else begin
            winner = idx[SEL_W-1:0];
        end
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// rtl/bus_source_arbiter.sv - registered bus source select with lock and multi-drive error tracking
module bus_source_arbiter
    import bus_pkg::*;
#(
    parameter int N_SRC   = BUS_N_SRC,
    parameter int SEL_W   = $clog2(N_SRC),
    parameter int RR_MODE = ARB_FIXED,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_SRC-1:0] req,
    input  logic             lock,
    input  logic             err_clr,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             multi_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [N_SRC-1:0] REQ_ONE = {{(N_SRC-1){1'b0}}, 1'b1};

    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             multi_err_q, multi_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] winner;
    logic             found;
    logic             hold;
    logic             multi;

    assign start = (RR_MODE == ARB_RR) ? ptr_q : '0;

    rr_priority_pick #(
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_pick (
        .req    (req),
        .start  (start),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        hold        = lock && sel_valid_q && req[sel_q];
        multi       = |(req & (req - REQ_ONE));
        sel_d       = sel_q;
        sel_valid_d = 1'b0;
        ptr_d       = ptr_q;
        if (hold) begin
            sel_valid_d = 1'b1;
        end else if (found) begin
            sel_d       = winner;
            sel_valid_d = 1'b1;
            if (RR_MODE == ARB_RR) begin
                ptr_d = (winner == SEL_W'(N_SRC-1)) ? '0 : winner + SEL_W'(1);
            end
        end

        // A new multi-drive event outranks err_clr in the same cycle.
        multi_err_d = multi_err_q;
        if (multi) begin
            multi_err_d = 1'b1;
        end else if (err_clr) begin
            multi_err_d = 1'b0;
        end

        err_cnt_d = err_cnt_q;
        if (multi && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            ptr_q       <= '0;
            multi_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            ptr_q       <= ptr_d;
            multi_err_q <= multi_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign multi_err = multi_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// tb/tb_bus_source_arbiter.sv - scoreboard bench for fixed, round-robin and 2-bit-counter arbiters
module tb_bus_source_arbiter;
    import bus_pkg::*;

    typedef struct {
        int    cyc;
        int    dut;
        int    sel;
        bit    valid;
        bit    merr;
        int    cnt;
        string name;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr_a   [3];
    logic [23:0] req_a   [3];
    logic        lock_a  [3];
    logic        eclr_a  [3];
    logic [4:0]  sel_o   [3];
    logic        valid_o [3];
    logic        merr_o  [3];
    logic [7:0]  cnt0, cnt1;
    logic [1:0]  cnt2;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bus_source_arbiter #(.N_SRC(BUS_N_SRC), .RR_MODE(ARB_FIXED), .CNT_W(8)) u_fix (
        .clk(clk), .clr(clr_a[0]), .req(req_a[0]), .lock(lock_a[0]), .err_clr(eclr_a[0]),
        .sel(sel_o[0]), .sel_valid(valid_o[0]), .multi_err(merr_o[0]), .err_cnt(cnt0));

    bus_source_arbiter #(.N_SRC(BUS_N_SRC), .RR_MODE(ARB_RR), .CNT_W(8)) u_rr (
        .clk(clk), .clr(clr_a[1]), .req(req_a[1]), .lock(lock_a[1]), .err_clr(eclr_a[1]),
        .sel(sel_o[1]), .sel_valid(valid_o[1]), .multi_err(merr_o[1]), .err_cnt(cnt1));

    bus_source_arbiter #(.N_SRC(BUS_N_SRC), .RR_MODE(ARB_FIXED), .CNT_W(2)) u_sat (
        .clk(clk), .clr(clr_a[2]), .req(req_a[2]), .lock(lock_a[2]), .err_clr(eclr_a[2]),
        .sel(sel_o[2]), .sel_valid(valid_o[2]), .multi_err(merr_o[2]), .err_cnt(cnt2));

    task automatic step(input int d, input logic c, input logic [23:0] r, input logic l,
                        input logic ec, input int es, input bit ev, input bit em,
                        input int ecnt, input string nm);
        exp_t e;
        clr_a[d]  = c;
        req_a[d]  = r;
        lock_a[d] = l;
        eclr_a[d] = ec;
        e.cyc   = cyc + 1;
        e.dut   = d;
        e.sel   = es;
        e.valid = ev;
        e.merr  = em;
        e.cnt   = ecnt;
        e.name  = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every expectation due on the edge just taken.
    initial begin
        exp_t e;
        int   a_sel, a_cnt;
        bit   a_v, a_m;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                a_sel = int'(sel_o[e.dut]);
                a_v   = valid_o[e.dut];
                a_m   = merr_o[e.dut];
                case (e.dut)
                    0:       a_cnt = int'(cnt0);
                    1:       a_cnt = int'(cnt1);
                    default: a_cnt = int'(cnt2);
                endcase
                n_check++;
                if (e.cyc != cyc || a_sel != e.sel || a_v != e.valid || a_m != e.merr || a_cnt != e.cnt) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cyc%0d: got sel=%0d valid=%0d merr=%0d cnt=%0d, want sel=%0d valid=%0d merr=%0d cnt=%0d at cyc%0d",
                             e.name, e.dut, cyc, a_sel, a_v, a_m, a_cnt, e.sel, e.valid, e.merr, e.cnt, e.cyc);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            clr_a[d] = 1'b1; req_a[d] = '0; lock_a[d] = 1'b0; eclr_a[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Fixed priority: reset with all requests, single-source sweep, error flag/counter
        step(0, 1, 24'hFFFFFF, 0, 0, 0, 0, 0, 0, "reset_fix");
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 24'(1) << i, 0, 0, i, 1, 0, 0, $sformatf("sweep%0d", i));
        end
        step(0, 0, 24'h000300, 0, 0, 8, 1, 1, 1, "fix_multi");
        step(0, 0, 24'h000000, 0, 0, 8, 0, 1, 1, "fix_idle_hold");
        step(0, 0, 24'h000000, 0, 1, 8, 0, 0, 1, "fix_errclr");
        step(0, 0, 24'h000003, 0, 1, 0, 1, 1, 2, "errclr_set_wins");

        // Lock on the fixed arbiter
        step(0, 1, 24'h000000, 0, 0, 0, 0, 0, 0, "reset_lock");
        step(0, 0, 24'h000010, 1, 0, 4, 1, 0, 0, "lock_first");
        step(0, 0, 24'h000030, 1, 0, 4, 1, 1, 1, "lock_hold_hi");
        step(0, 0, 24'h000018, 1, 0, 4, 1, 1, 2, "lock_hold_lo");
        step(0, 0, 24'h000020, 1, 0, 5, 1, 1, 2, "lock_drop_req");
        step(0, 0, 24'h000021, 0, 0, 0, 1, 1, 3, "lock_off");

        // Round-robin wrap between SRC_R0 and SRC_C
        step(1, 1, 24'h000000, 0, 0, 0, 0, 0, 0, "reset_rr");
        step(1, 0, 24'h800001, 0, 0, SRC_R0, 1, 1, 1, "rr_a");
        step(1, 0, 24'h800001, 0, 0, SRC_C,  1, 1, 2, "rr_b");
        step(1, 0, 24'h800001, 0, 0, SRC_R0, 1, 1, 3, "rr_c");
        step(1, 0, 24'h800001, 0, 0, SRC_C,  1, 1, 4, "rr_d");
        step(1, 0, 24'h000000, 0, 0, SRC_C,  0, 1, 4, "rr_idle");
        step(1, 0, 24'h800002, 0, 0, SRC_R1, 1, 1, 5, "rr_ptr0");
        step(1, 0, 24'h800002, 0, 0, SRC_C,  1, 1, 6, "rr_ptr2");

        // 2-bit counter saturation while locked, then clear mid-lock
        step(2, 1, 24'h000000, 0, 0, 0, 0, 0, 0, "reset_sat");
        step(2, 0, 24'h000006, 1, 0, 1, 1, 1, 1, "sat1");
        step(2, 0, 24'h000006, 1, 0, 1, 1, 1, 2, "sat2");
        step(2, 0, 24'h000006, 1, 0, 1, 1, 1, 3, "sat3");
        step(2, 0, 24'h000006, 1, 0, 1, 1, 1, 3, "sat4");
        step(2, 0, 24'h000006, 1, 0, 1, 1, 1, 3, "sat5");
        step(2, 1, 24'h000006, 1, 0, 0, 0, 0, 0, "clr_mid_lock");
        step(2, 0, 24'h000006, 1, 0, 1, 1, 1, 1, "after_clr");

        repeat (3) @(posedge clk);
        #5;
        if (sb.size() != 0) begin
            n_check++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_source_arbiter.md
# bus_source_arbiter

Parametrised successor to the datapath's bus-source encoder. It takes N one-per-source drive requests (R0out…Cout and future sources) and produces a registered encoded select for the bus multiplexer. It supports fixed-priority or round-robin resolution, an optional grant lock for multi-cycle transfers, and sticky multi-drive error detection with a saturating event counter. It sits between the control unit and the bus multiplexer, replacing the combinational one-hot encoder.

## Interface
Parameters:
- N_SRC, 24, number of bus sources; legal range 2..64.
- SEL_W, $clog2(N_SRC), select width. Derived; do not override.
- RR_MODE, 0, resolution mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- CNT_W, 8, width of the error event counter.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- req  in  N_SRC  source drive requests; bit i corresponds to source index i.
- lock  in  1  holds the current grant while the granted source keeps requesting.
- err_clr  in  1  clears the sticky error flag (the counter is not cleared).
- sel  out  SEL_W  registered encoded index of the granted source.
- sel_valid  out  1  registered; high when sel drives the bus.
- multi_err  out  1  sticky; set when more than one req bit was high in a cycle.
- err_cnt  out  CNT_W  saturating count of multi-drive cycles.

## Operation
- Each cycle, the arbiter computes a winner from req and registers it into sel and sel_valid.
- Fixed mode: the winner is the lowest set index of req.
- Round-robin mode:
  - The winner is the first set index at or above pointer ptr, searching upward and wrapping N_SRC-1 → 0.
  - After each grant, ptr = winner+1, which wraps to 0 when the winner is N_SRC-1.
  - ptr is unchanged when there is no grant.
- Lock: if lock=1, sel_valid=1 and req[sel]=1, the grant is held.
  - sel is unchanged and ptr does not advance.
  - Other requesters are ignored for resolution but still count toward the error check.
- Lock release: the lock is released when lock=0 or req[sel]=0. Normal resolution resumes that same cycle.
- No requests (req=0): sel_valid←0 and sel holds its last value.
- Multi-drive check: if popcount(req)>1, multi_err←1 and err_cnt←err_cnt+1. err_cnt saturates at 2^CNT_W−1.
- The grant is still produced on a multi-drive cycle; it is not suppressed.
- err_clr and a new multi-drive event in the same cycle: multi_err stays 1 (set wins).
- req bits at or above N_SRC do not exist. There are no reserved or padding inputs.

## Timing
- Latency is 1 cycle: req sampled at edge k appears on sel/sel_valid after edge k.
- multi_err and err_cnt update on the same edge as the grant they relate to.
- Reset values on the clr edge: sel=0, sel_valid=0, multi_err=0, err_cnt=0, ptr=0.
- clr dominates all other inputs.
- Reset during a lock drops the grant. After clr, the first grant follows the normal 1-cycle latency.
- There is no combinational path from any input to any output.

## Structure
- Shared package bus_pkg:
  - Source index constants SRC_R0=0 … SRC_R15=15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_C=23.
  - BUS_N_SRC=24.
  - Mode constants ARB_FIXED=0 and ARB_RR=1.
- One sub-module, rr_priority_pick:
  - Combinational block, parametrised by N_SRC.
  - Inputs: req and start pointer.
  - Outputs: winner index and found flag.
  - Implementation: double-width masked priority search.
  - Fixed mode instantiates it with start fixed at 0.
- The top level contains all registers: sel, sel_valid, ptr, multi_err and err_cnt.

## Test plan
- Reset: assert clr with req=24'hFFFFFF → sel=0, sel_valid=0, multi_err=0, err_cnt=0 after the edge.
- Single-source sweep, fixed mode: for each i in 0..23, req=1<<i → one cycle later sel=i, sel_valid=1, multi_err stays 0.
- Fixed priority and error counting: req=0x000300 → sel=8, multi_err=1, err_cnt=1. Then req=0 → sel_valid=0, sel stays 8. Then pulse err_clr → multi_err=0, err_cnt=1.
- Round-robin wrap: req=0x800001 held for 4 cycles → sel sequence 0, 23, 0, 23. ptr wraps 0→1→0→1.
- Lock: req=0x000010 with lock=1, then req=0x000030 with lock=1 → sel stays 4 and multi_err=1. Then drop req[4] → sel=5 on the next cycle.
- Counter saturation and clr mid-lock:
  - With CNT_W=2, apply 5 multi-drive cycles → err_cnt=3.
  - Then assert clr while locked → all outputs return to their reset values.
